// File: rtl/poly_unload_bram_pkg.sv
// Shared constants and state encoding for draining the Saber multiplier
// accumulator into BRAM.
package poly_unload_bram_pkg;

  localparam int POLY_BITS     = 3328;
  localparam int WORDS_RAW     = 52;
  localparam int WORDS_COEFF4X = 64;
  localparam int ADDR_W        = 6;
  localparam int DATA_W        = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Index of the final word of a run: 52 raw words or 64 packed words.
  function automatic logic [ADDR_W-1:0] last_index(input logic coeff4x);
    if (coeff4x) begin
      last_index = ADDR_W'(WORDS_COEFF4X - 1);
    end else begin
      last_index = ADDR_W'(WORDS_RAW - 1);
    end
  endfunction

endpackage

// File: rtl/poly_unload_bram_if.sv
// Caller/multiplier/BRAM-side signals of the accumulator unload engine.
interface poly_unload_bram_if;
  import poly_unload_bram_pkg::*;

  logic              start;
  logic              coeff4x_mode;
  logic              hold;
  logic [DATA_W-1:0] acc64_in;
  logic [DATA_W-1:0] coeff4x_in;
  logic              read;
  logic              read64;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_address_relative;
  logic [DATA_W-1:0] bram_din;
  logic              busy;
  logic              done;

  modport master (
    output start, coeff4x_mode, hold, acc64_in, coeff4x_in,
    input  read, read64, bram_we, bram_address_relative, bram_din, busy, done
  );

  modport slave (
    input  start, coeff4x_mode, hold, acc64_in, coeff4x_in,
    output read, read64, bram_we, bram_address_relative, bram_din, busy, done
  );

endinterface

// File: rtl/poly_unload_bram.sv
// Drains the multiplier accumulator into BRAM one 64-bit word per cycle,
// rotating it a full 3328 bits so it ends up restored.
module poly_unload_bram
  import poly_unload_bram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  poly_unload_bram_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic              mode_q, mode_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              take_s;

  assign take_s = (state_q == ST_DRAIN) && !bus.hold;

  // Shift commands are combinational so the multiplier rotates in the take cycle.
  assign bus.read   = take_s && mode_q;
  assign bus.read64 = take_s && !mode_q;

  assign bus.bram_we               = we_q;
  assign bus.bram_address_relative = addr_q;
  assign bus.bram_din              = din_q;
  assign bus.busy                  = (state_q == ST_DRAIN) || (state_q == ST_FLUSH);
  assign bus.done                  = (state_q == ST_DONE);

  // Next-state, word counter and write-port computation.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mode_d  = mode_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_DRAIN;
          k_d     = '0;
          mode_d  = bus.coeff4x_mode;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (take_s) begin
          we_d   = 1'b1;
          addr_d = k_q;
          din_d  = mode_q ? bus.coeff4x_in : bus.acc64_in;
          k_d    = k_q + ADDR_W'(1);
          if (k_q == last_index(mode_q)) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      // The last registered word is written while sitting here.
      ST_FLUSH: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!bus.start) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, mode and write-port registers; reset drops any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      mode_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

endmodule
